// File: rtl/pulse_sync_sched_pkg.sv
// rtl/pulse_sync_sched_pkg.sv - shared types and helpers for the pulse synchronizer scheduler
package pulse_sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int DROP_CNT_W = 8;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pulse_sync_sched_rr_arb.sv
// rtl/pulse_sync_sched_rr_arb.sv - combinational rotating-priority search starting after last_i
module pulse_sync_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] nz_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    grant_o
);

    // Walk offsets from farthest to nearest so the nearest hit after last_i wins.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (nz_i[ID_W'((int'(last_i) + off) % NUM_REQ)]) begin
                valid_o = 1'b1;
                grant_o = ID_W'((int'(last_i) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/pulse_sync_sched.sv
// rtl/pulse_sync_sched.sv - round-robin pulse scheduler for a shared toggle synchronizer (option: PULSE_SYNC_SCHED_DROP_CNT_EN)
module pulse_sync_sched
    import pulse_sync_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  CNT_W   = 3,
    parameter int  GAP_CYC = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               clr_ovf_i,
    output logic               puls_o,
    output logic [ID_W-1:0]    id_o,
    output logic               busy_o,
    output logic [NUM_REQ-1:0] pend_o,
    output logic [NUM_REQ-1:0] ovf_o
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sched_state_t                    state_q, state_d;
    logic [NUM_REQ-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]              ovf_q, ovf_d;
    logic [NUM_REQ-1:0]              nz;
    logic [NUM_REQ-1:0]              drop;
    logic [ID_W-1:0]                 grant_q, grant_d;
    logic [ID_W-1:0]                 last_q, last_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            arb_valid;
    logic [ID_W-1:0]                 arb_grant;

    pulse_sync_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .nz_i    (nz),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant)
    );

    // Simultaneous inc and dec cancel, so a granted requester re-pulsing keeps its count.
    always_comb begin
        cnt_d = cnt_q;
        drop  = '0;
        nz    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            nz[k] = |cnt_q[k];
            if (req_i[k] && !((state_q == ISSUE) && (grant_q == ID_W'(k)))) begin
                if (cnt_q[k] == CNT_MAX) begin
                    drop[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end else if (!req_i[k] && (state_q == ISSUE) && (grant_q == ID_W'(k))) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
        ovf_d = (clr_ovf_i ? '0 : ovf_q) | drop;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (en_i && arb_valid) begin
                    grant_d = arb_grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_d  = grant_q;
                gap_d   = GAP_W'(GAP_CYC - 1);
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= '0;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

    assign puls_o = (state_q == ISSUE);
    assign busy_o = (state_q != IDLE);
    assign id_o   = grant_q;
    assign pend_o = nz;
    assign ovf_o  = ovf_q;

`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
    localparam int DS_W = DROP_CNT_W + 1;

    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [4:0]            drop_pop;
    logic [DS_W-1:0]       drop_sum;

    always_comb begin
        drop_pop = popcount16(16'(drop));
        drop_sum = {1'b0, drop_cnt_q} + DS_W'(drop_pop);
        if (clr_ovf_i) begin
            drop_cnt_d = DROP_CNT_W'(drop_pop);
        end else if (drop_sum[DROP_CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_pulse_sync_sched.sv
// tb/tb_pulse_sync_sched.sv - self-checking bench for pulse_sync_sched
module tb_pulse_sync_sched;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 3;
    localparam int GAP_CYC = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       en;
    logic       clr;
    logic       puls;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] ovf;
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_sync_sched #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req),
        .en_i      (en),
        .clr_ovf_i (clr),
        .puls_o    (puls),
        .id_o      (id),
        .busy_o    (busy),
        .pend_o    (pend),
        .ovf_o     (ovf)
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt)
`endif
    );

    // Reference model: queued event counts plus "cycles left in the busy window".
    int       m_cnt[4];
    bit [3:0] m_ovf;
    int       m_last;
    int       m_id;
    int       m_remain;
    int       m_drop;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_ovf    = '0;
        m_last   = NUM_REQ - 1;
        m_id     = 0;
        m_remain = 0;
        m_drop   = 0;
    endfunction

    function automatic logic [11:0] model_out();
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = (m_cnt[k] > 0);
        return {(m_remain == GAP_CYC + 1), 2'(m_id), (m_remain > 0), p, m_ovf};
    endfunction

    function automatic void model_step(bit r, bit [3:0] rq, bit e, bit c);
        int       old[4];
        bit       issuing;
        bit       any;
        int       dropped;
        bit [3:0] setb;
        if (!r) begin
            model_reset();
            return;
        end
        issuing = (m_remain == GAP_CYC + 1);
        any     = 0;
        dropped = 0;
        setb    = '0;
        for (int k = 0; k < 4; k++) begin
            old[k] = m_cnt[k];
            any    = any | (old[k] > 0);
        end
        for (int k = 0; k < 4; k++) begin
            bit dec;
            dec = issuing && (m_id == k);
            if (rq[k] && !dec) begin
                if (m_cnt[k] == CMAX) begin
                    setb[k] = 1;
                    dropped++;
                end else begin
                    m_cnt[k]++;
                end
            end else if (dec && !rq[k]) begin
                m_cnt[k]--;
            end
        end
        m_ovf  = (c ? 4'b0 : m_ovf) | setb;
        m_drop = c ? dropped : ((m_drop + dropped > 255) ? 255 : m_drop + dropped);
        if (m_remain > 0) begin
            if (issuing) m_last = m_id;
            m_remain--;
        end else if (e && any) begin
            for (int off = NUM_REQ; off >= 1; off--) begin
                if (old[(m_last + off) % NUM_REQ] > 0) m_id = (m_last + off) % NUM_REQ;
            end
            m_remain = GAP_CYC + 1;
        end
    endfunction

    task automatic step(input bit r, input logic [3:0] rq, input bit e, input bit c);
        rstn = r;
        req  = rq;
        en   = e;
        clr  = c;
        @(posedge clk);
        model_step(r, rq, e, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        checks++;
        if ({puls, id, busy, pend, ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=000", {puls, id, busy, pend, ovf});
        end
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
        end
`endif
    endtask

    task automatic test_single();
        logic [7:0] ps;
        logic [7:0] bs;
        logic [1:0] id_at_pulse;
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0100, 1, 0);
        id_at_pulse = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            ps[i-1] = puls;
            bs[i-1] = busy;
            if (i == 2) id_at_pulse = id;
            step(1, 4'b0000, 1, 0);
        end
        checks++;
        if (ps !== 8'b0000_0010) begin
            failures++;
            $display("FAIL single_puls_timing got=%b exp=00000010", ps);
        end
        checks++;
        if (bs !== 8'b0011_1110) begin
            failures++;
            $display("FAIL single_busy_window got=%b exp=00111110", bs);
        end
        checks++;
        if (id_at_pulse !== 2'd2) begin
            failures++;
            $display("FAIL single_id got=%0d exp=2", id_at_pulse);
        end
        checks++;
        if (pend !== 4'b0000 || id !== 2'd2) begin
            failures++;
            $display("FAIL single_after pend=%b id=%0d exp pend=0000 id=2", pend, id);
        end
    endtask

    task automatic test_all_four();
        int cyc[$];
        int ids[$];
        step(0, 4'b0000, 0, 0);
        step(1, 4'b1111, 1, 0);
        for (int i = 1; i <= 30; i++) begin
            if (puls === 1'b1) begin
                cyc.push_back(i);
                ids.push_back(int'(id));
            end
            step(1, 4'b0000, 1, 0);
        end
        checks++;
        if (cyc.size() != 4) begin
            failures++;
            $display("FAIL all_four_count got=%0d exp=4", cyc.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (cyc[j] != 2 + 6 * j || ids[j] != j) begin
                    failures++;
                    $display("FAIL all_four_pulse%0d cycle=%0d id=%0d exp cycle=%0d id=%0d",
                             j, cyc[j], ids[j], 2 + 6 * j, j);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        int bad_id;
        step(0, 4'b0000, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 4'b0010, 0, 0);
        checks++;
        if (pend !== 4'b0010 || ovf !== 4'b0010 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold pend=%b ovf=%b busy=%b exp 0010 0010 0", pend, ovf, busy);
        end
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd3) begin
            failures++;
            $display("FAIL sat_drop_cnt got=%0d exp=3", drop_cnt);
        end
`endif
        n      = 0;
        bad_id = 0;
        for (int i = 0; i < 60; i++) begin
            if (puls === 1'b1) begin
                n++;
                if (id !== 2'd1) bad_id++;
            end
            step(1, 4'b0000, 1, 0);
        end
        checks++;
        if (n != 7 || bad_id != 0 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL sat_drain pulses=%0d bad_id=%0d pend=%b exp 7 0 0000", n, bad_id, pend);
        end
    endtask

    task automatic test_simultaneous();
        int ids[$];
        step(0, 4'b0000, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 1);
        checks++;
        if (ovf !== 4'b0001) begin
            failures++;
            $display("FAIL ovf_set_beats_clr got=%b exp=0001", ovf);
        end
        step(1, 4'b0000, 0, 1);
        checks++;
        if (ovf !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0000", ovf);
        end
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            failures++;
            $display("FAIL drop_clear got=%0d exp=0", drop_cnt);
        end
`endif
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0010, 1, 0);
        step(1, 4'b0100, 1, 0);
        checks++;
        if (puls !== 1'b1 || id !== 2'd1) begin
            failures++;
            $display("FAIL issue_grant puls=%b id=%0d exp 1 1", puls, id);
        end
        step(1, 4'b0010, 1, 0);
        checks++;
        if (pend !== 4'b0110) begin
            failures++;
            $display("FAIL issue_repulse_pend got=%b exp=0110", pend);
        end
        for (int i = 0; i < 30; i++) begin
            if (puls === 1'b1) ids.push_back(int'(id));
            step(1, 4'b0000, 1, 0);
        end
        checks++;
        if (ids.size() != 2 || ids[0] != 2 || ids[1] != 1) begin
            failures++;
            $display("FAIL issue_repulse_order n=%0d first=%0d second=%0d exp 2 2 1", ids.size(),
                     (ids.size() > 0) ? ids[0] : -1, (ids.size() > 1) ? ids[1] : -1);
        end
    endtask

    task automatic test_en_gap();
        int n;
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0011, 1, 0);
        step(1, 4'b0000, 1, 0);
        checks++;
        if (puls !== 1'b1 || id !== 2'd0) begin
            failures++;
            $display("FAIL en_gap_first puls=%b id=%0d exp 1 0", puls, id);
        end
        step(1, 4'b0000, 1, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (puls === 1'b1) n++;
            step(1, 4'b0000, 0, 0);
        end
        checks++;
        if (n != 0 || busy !== 1'b0 || pend !== 4'b0010) begin
            failures++;
            $display("FAIL en_gap_hold pulses=%0d busy=%b pend=%b exp 0 0 0010", n, busy, pend);
        end
        step(1, 4'b0000, 1, 0);
        checks++;
        if (puls !== 1'b1 || id !== 2'd1) begin
            failures++;
            $display("FAIL en_gap_resume puls=%b id=%0d exp 1 1", puls, id);
        end
    endtask

    task automatic test_reset_gap();
        step(0, 4'b0000, 0, 0);
        step(1, 4'b1111, 1, 0);
        step(1, 4'b0000, 1, 0);
        step(1, 4'b0000, 1, 0);
        checks++;
        if (busy !== 1'b1 || puls !== 1'b0 || pend !== 4'b1110) begin
            failures++;
            $display("FAIL rst_gap_pre busy=%b puls=%b pend=%b exp 1 0 1110", busy, puls, pend);
        end
        step(0, 4'b0000, 1, 0);
        checks++;
        if ({puls, id, busy, pend, ovf} !== 12'h000) begin
            failures++;
            $display("FAIL rst_gap_clear got=%h exp=000", {puls, id, busy, pend, ovf});
        end
        step(1, 4'b1001, 1, 0);
        step(1, 4'b0000, 1, 0);
        checks++;
        if (puls !== 1'b1 || id !== 2'd0) begin
            failures++;
            $display("FAIL rst_gap_first_grant puls=%b id=%0d exp 1 0", puls, id);
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_v;
        logic [3:0]  rq;
        bit          r;
        bit          e;
        bit          c;
        int          bad;
        step(0, 4'b0000, 0, 0);
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            exp_v = model_out();
            checks++;
            if ({puls, id, busy, pend, ovf} !== exp_v) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d got=%h exp=%h", i, {puls, id, busy, pend, ovf}, exp_v);
            end
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
            checks++;
            if (drop_cnt !== 8'(m_drop)) begin
                failures++;
                bad++;
                if (bad <= 10) $display("FAIL random_drop%0d got=%0d exp=%0d", i, drop_cnt, m_drop);
            end
`endif
            r  = ($urandom_range(0, 299) != 0);
            e  = ((i % 700) < 550) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 40) == 0);
            rq = ((i % 600) < 150) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
            step(r, rq, e, c);
        end
    endtask

    initial begin
        rstn = 1'b0;
        req  = '0;
        en   = 1'b0;
        clr  = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_saturation();
        test_simultaneous();
        test_en_gap();
        test_reset_gap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
